// File: rtl/conv_output_packer_if.sv
// Packer data-plane bundle: accumulator input with backpressure, and the
// first-word-fall-through output stream toward the DDR write path.
interface conv_output_packer_if #(
  parameter int unsigned N_KERNEL   = 4,
  parameter int unsigned B_PIXEL    = 16,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [2*B_PIXEL*N_KERNEL-1:0] acc_i;
  logic                          acc_valid;
  logic                          pipe_stall;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          dout_valid;
  logic                          dout_ready;

  modport master (
    output acc_i, acc_valid, dout_ready,
    input  pipe_stall, dout, dout_valid
  );

  modport slave (
    input  acc_i, acc_valid, dout_ready,
    output pipe_stall, dout, dout_valid
  );
endinterface

// File: rtl/conv_output_packer.sv
// Requantizes N_KERNEL accumulator lanes (round, ReLU, saturate), packs them into
// one word and buffers it in an output FIFO that backpressures the conv pipe.
module conv_output_packer #(
  parameter int unsigned N_KERNEL   = 4,
  parameter int unsigned B_PIXEL    = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned B_CNT      = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [31:0]         cfg,
  conv_output_packer_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err_ovf
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned OW    = AW + 2;
  localparam int unsigned B_ACC = 2 * B_PIXEL;
  localparam int unsigned B_R   = B_ACC + 1;
  localparam logic signed [B_R-1:0] SAT_MAX  = B_R'((1 << (B_PIXEL - 1)) - 1);
  localparam logic signed [B_R-1:0] SAT_MIN  = -SAT_MAX - B_R'(1);
  localparam logic [OW-1:0]         STALL_TH = OW'(FIFO_DEPTH - 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [4:0]       r_shift;
  logic             r_relu;
  logic [B_CNT-1:0] r_n_out, r_cnt, w_cnt_inc;
  logic             w_load, w_accept, w_cfg_unused;

  logic                  r_s1_valid, r_s2_valid;
  logic signed [B_R-1:0] r_s1 [N_KERNEL];
  logic signed [B_R-1:0] w_s1 [N_KERNEL];
  logic signed [B_R-1:0] w_sum [N_KERNEL];
  logic signed [B_R-1:0] w_rnd;
  logic [DATA_WIDTH-1:0] w_pack, r_s2_data;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic [DATA_WIDTH-1:0] r_dout, w_head;
  logic [OW-1:0]         w_occ;
  logic                  w_full, w_empty, w_push, w_pop, w_drop;
  logic                  r_stall, r_err_ovf;

  assign w_cfg_unused = ^cfg[31:6+B_CNT];
  assign w_load       = cfg_we && (r_state == S_IDLE || r_state == S_DONE);
  // The cnt != n_out term is the saturation: nothing past n_out is accepted.
  assign w_accept     = (r_state == S_RUN) && bus.acc_valid && (r_cnt != r_n_out);
  assign w_cnt_inc    = r_cnt + B_CNT'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_state_next = S_RUN;
      S_RUN:   if (r_n_out == '0 || (w_accept && w_cnt_inc == r_n_out)) w_state_next = S_DRAIN;
      S_DRAIN: if (!r_s1_valid && !r_s2_valid && w_empty) w_state_next = S_DONE;
      S_DONE:  if (w_load) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_n_out <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_shift <= cfg[4:0];
      r_relu  <= cfg[5];
      r_n_out <= cfg[6 +: B_CNT];
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_inc;
    end
  end

  assign w_rnd = (r_shift == '0) ? '0 : (B_R'(1) << (r_shift - 5'd1));

  always_comb begin
    for (int unsigned k = 0; k < N_KERNEL; k++) begin
      w_sum[k] = B_R'(signed'(bus.acc_i[k*B_ACC +: B_ACC])) + w_rnd;
      w_s1[k]  = w_sum[k] >>> r_shift;
    end
  end

  always_comb begin
    w_pack = '0;
    for (int unsigned k = 0; k < N_KERNEL; k++) begin
      if (r_relu && r_s1[k][B_R-1])  w_pack[k*B_PIXEL +: B_PIXEL] = '0;
      else if (r_s1[k] > SAT_MAX)    w_pack[k*B_PIXEL +: B_PIXEL] = SAT_MAX[B_PIXEL-1:0];
      else if (r_s1[k] < SAT_MIN)    w_pack[k*B_PIXEL +: B_PIXEL] = SAT_MIN[B_PIXEL-1:0];
      else                           w_pack[k*B_PIXEL +: B_PIXEL] = r_s1[k][B_PIXEL-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_KERNEL; k++) r_s1[k] <= w_s1[k];
    r_s2_data <= w_pack;
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && bus.dout_ready;
  assign w_push    = r_s2_valid && (!w_full || w_pop);
  assign w_drop    = r_s2_valid && w_full && !w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  // A word written this cycle becomes the head when the read pointer lands on it.
  assign w_head    = (w_push && w_rd_next == r_wr_ptr) ? r_s2_data : r_mem[w_rd_next];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  assign w_occ = OW'(r_count) + OW'(r_s1_valid) + OW'(r_s2_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_stall   <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_count_next != '0) r_dout <= w_head;
      r_stall  <= (w_occ >= STALL_TH);
      if (w_load)      r_err_ovf <= 1'b0;
      else if (w_drop) r_err_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s2_data;
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = !w_empty;
  assign bus.pipe_stall = r_stall;
  assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign err_ovf        = r_err_ovf;
endmodule

// File: tb/tb_conv_output_packer.sv
// Bench for conv_output_packer: hand-computed vector table, backpressure,
// overflow and mid-run reset sequences, with a queue scoreboard on the output.
module tb_conv_output_packer;
  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [31:0] cfg;
  logic        busy, done, err_ovf;

  conv_output_packer_if #(.N_KERNEL(4), .B_PIXEL(16), .DATA_WIDTH(64)) bus ();

  conv_output_packer #(
    .N_KERNEL(4), .B_PIXEL(16), .DATA_WIDTH(64), .FIFO_DEPTH(16), .B_CNT(20)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg(cfg), .bus(bus),
    .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [127:0] acc;
    int unsigned  sh;
    bit           relu;
    logic [63:0]  exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_lane(input logic [31:0] a, input int unsigned sh, input bit relu);
    longint v;
    v = longint'(signed'(a));
    if (sh != 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [63:0] model_word(input logic [127:0] acc, input int unsigned sh, input bit relu);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = model_lane(acc[k*32 +: 32], sh, relu);
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", bus.dout, 64'hx);
      end else begin
        check("scoreboard_dout", bus.dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int unsigned sh, input bit relu, input int unsigned n);
    cfg    = {6'd0, 20'(n), relu, 5'(sh)};
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [127:0] acc);
    bus.acc_i     = acc;
    bus.acc_valid = 1'b1;
    tick();
    bus.acc_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int lat;
    int sent;
    bit seen_stall;
    logic [127:0] acc;

    tbl[0] = '{{-32'sd40000, 32'sd40000, -32'sd3, 32'sd5}, 0, 1'b0, 64'h8000_7FFF_FFFD_0005};
    tbl[1] = '{{-32'sd9, 32'sd7, -32'sd24, 32'sd24}, 4, 1'b0, 64'hFFFF_0000_FFFF_0002};
    tbl[2] = '{{-32'sd1, 32'sd0, 32'sd100, -32'sd100}, 0, 1'b1, 64'h0000_0000_0064_0000};
    tbl[3] = '{{32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF}, 31, 1'b0, 64'h0000_0001_FFFF_0001};
    tbl[4] = '{{32'sd65536, 32'sd65535, -32'sd3, 32'sd3}, 1, 1'b1, 64'h7FFF_7FFF_0000_0002};
    tbl[5] = '{{-32'sd32769, 32'sd32768, -32'sd32768, 32'sd32767}, 0, 1'b0, 64'h8000_7FFF_8000_7FFF};

    rst = 1'b1; cfg_we = 1'b0; cfg = '0;
    bus.acc_i = '0; bus.acc_valid = 1'b0; bus.dout_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_dout_valid", {63'd0, bus.dout_valid}, 64'd0);
    check("rst_dout", bus.dout, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err_ovf", {63'd0, err_ovf}, 64'd0);
    check("rst_pipe_stall", {63'd0, bus.pipe_stall}, 64'd0);

    // single-word layers from the table: value, latency, done after pop
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      configure(tbl[i].sh, tbl[i].relu, 1);
      check("busy_run", {63'd0, busy}, 64'd1);
      exp_q.push_back(tbl[i].exp);
      send(tbl[i].acc);
      lat = 1;
      while (!bus.dout_valid && lat < 10) begin
        tick();
        lat++;
      end
      check("latency", 64'(lat), 64'd3);
      check("table_dout", bus.dout, tbl[i].exp);
      wait_done(10);
      check("busy_done", {63'd0, busy}, 64'd0);
    end

    // n_out == 0 finishes with no output
    configure(0, 1'b0, 0);
    bus.acc_i = '1; bus.acc_valid = 1'b1;
    wait_done(10);
    bus.acc_valid = 1'b0;
    repeat (4) tick();
    check("nout0_no_output", {63'd0, bus.dout_valid}, 64'd0);

    // backpressure: consumer stalled, producer honours pipe_stall
    configure(2, 1'b0, 40);
    bus.dout_ready = 1'b0;
    sent = 0;
    seen_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.pipe_stall) seen_stall = 1'b1;
      if (!bus.pipe_stall && sent < 40) begin
        acc = {$urandom, $urandom, $urandom, $urandom};
        bus.acc_i = acc; bus.acc_valid = 1'b1;
        exp_q.push_back(model_word(acc, 2, 1'b0));
        sent++;
      end else begin
        bus.acc_valid = 1'b0;
      end
      tick();
    end
    bus.acc_valid = 1'b0;
    check("stall_seen", {63'd0, seen_stall}, 64'd1);
    check("stall_limited", {63'd0, (sent < 40)}, 64'd1);
    check("stall_no_ovf", {63'd0, err_ovf}, 64'd0);
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 400 && sent < 40; c++) begin
      if (!bus.pipe_stall) begin
        acc = {$urandom, $urandom, $urandom, $urandom};
        bus.acc_i = acc; bus.acc_valid = 1'b1;
        exp_q.push_back(model_word(acc, 2, 1'b0));
        sent++;
      end else begin
        bus.acc_valid = 1'b0;
      end
      tick();
    end
    bus.acc_valid = 1'b0;
    check("stall_all_sent", 64'(sent), 64'd40);
    wait_done(100);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);
    check("stall_end_no_ovf", {63'd0, err_ovf}, 64'd0);

    // overflow: stall ignored, words 17-20 must be dropped
    configure(0, 1'b0, 20);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = {32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)};
      if (i < 16) exp_q.push_back(model_word(acc, 0, 1'b0));
      send(acc);
    end
    repeat (4) tick();
    check("ovf_flag", {63'd0, err_ovf}, 64'd1);
    check("ovf_head_valid", {63'd0, bus.dout_valid}, 64'd1);
    check("ovf_busy", {63'd0, busy}, 64'd1);
    bus.dout_ready = 1'b1;
    wait_done(100);
    check("ovf_queue_empty", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", {63'd0, err_ovf}, 64'd1);

    // reset mid-run with words queued, then restart
    configure(0, 1'b0, 10);
    check("cfg_clears_ovf", {63'd0, err_ovf}, 64'd0);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc = {32'd7, 32'd6, 32'd5, 32'(100 + i)};
      exp_q.push_back(model_word(acc, 0, 1'b0));
      send(acc);
    end
    repeat (4) tick();
    check("pre_rst_valid", {63'd0, bus.dout_valid}, 64'd1);
    rst = 1'b1;
    tick();
    check("post_rst_valid", {63'd0, bus.dout_valid}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    configure(0, 1'b0, 1);
    bus.dout_ready = 1'b1;
    exp_q.push_back(64'h0004_0003_0002_0001);
    send({32'd4, 32'd3, 32'd2, 32'd1});
    wait_done(20);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
